// File: rtl/mfcc_pkg.sv
// Shared definitions for the MFCC frame buffering path: default sample
// width, default frame length and frame-number width, plus a constant
// log2 helper used to size pointers and RAM addresses.
package mfcc_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int FRAME_LEN_DEF = 400;   // 25 ms of audio at 16 kHz
    localparam int FNUM_W        = 8;

    // Smallest number of bits able to index 'value' distinct items.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mfcc_frame_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with
// a registered output (1-cycle read latency). Contents are never reset.
module mfcc_frame_ram
    import mfcc_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF,
    parameter int DEPTH = FRAME_LEN_DEF,
    parameter int AW    = 9
)(
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port: store the incoming word when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read port: capture the addressed word one cycle after the request.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mfcc_frame_buf.sv
// Multi-bank frame buffer: samples stream into a ring of banks, the oldest
// complete bank is exposed for random-access reads (1-cycle latency, optional
// 2-sample packing), and the consumer releases banks explicitly.
module mfcc_frame_buf
    import mfcc_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int NUM_BANKS = 2,
    parameter int PACK      = 0,
    parameter int ADDR_W    = 13,
    localparam int OUT_W    = 2 * DATA_W
)(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_valid_o,
    output logic [OUT_W-1:0]  rd_data_o,
    output logic              rd_err_o,
    input  logic              rd_done_i,
    output logic              frame_rdy_o,
    output logic [FNUM_W-1:0] frame_num_o,
    output logic              ovf_o
);

    localparam int BANK_W         = clog2(NUM_BANKS);
    localparam int PTR_W          = (clog2(FRAME_LEN) < 1) ? 1 : clog2(FRAME_LEN);
    localparam int FILL_W         = clog2(NUM_BANKS + 1);
    localparam int WORDS_PER_BANK = (PACK != 0) ? FRAME_LEN / 2 : FRAME_LEN;
    localparam int RAM_DEPTH      = NUM_BANKS * WORDS_PER_BANK;
    localparam int RAM_AW         = (clog2(RAM_DEPTH) < 1) ? 1 : clog2(RAM_DEPTH);
    localparam int PACK_SHIFT     = (PACK != 0) ? 1 : 0;

    localparam logic [RAM_AW-1:0] BANK_WORDS = RAM_AW'(WORDS_PER_BANK);
    localparam logic [ADDR_W:0]   RD_LIMIT   = (ADDR_W + 1)'(WORDS_PER_BANK);
    localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(FRAME_LEN - 1);
    localparam logic [FILL_W-1:0] FULL_FILL  = FILL_W'(NUM_BANKS);

    logic [PTR_W-1:0]  wrPtr_q,    wrPtr_d;
    logic [BANK_W-1:0] wrBank_q,   wrBank_d;
    logic [BANK_W-1:0] rdBank_q,   rdBank_d;
    logic [FILL_W-1:0] fill_q,     fill_d;
    logic [FNUM_W-1:0] frameNum_q, frameNum_d;
    logic              ovf_q,      ovf_d;
    logic              frameRdy_q;
    logic              rdValid_q;
    logic              rdErr_q;

    logic              wrFire;
    logic              frameDone;
    logic              releaseBank;
    logic              rdFire;
    logic              rdInRange;
    logic [RAM_AW-1:0] wrAddr;
    logic [RAM_AW-1:0] rdAddr;
    logic [OUT_W-1:0]  ramWord;

    assign wr_ready_o  = !reset_i && (fill_q != FULL_FILL);
    assign wrFire      = wr_valid_i && wr_ready_o;
    assign frameDone   = wrFire && (wrPtr_q == LAST_PTR);
    assign releaseBank = rd_done_i && (fill_q != '0);
    assign rdFire      = rd_req_i && frameRdy_q;
    assign rdInRange   = ({1'b0, rd_addr_i} < RD_LIMIT);

    // Packed mode stores even and odd samples in separate half-RAMs, so the
    // write word index is the sample index halved.
    assign wrAddr = RAM_AW'(wrBank_q) * BANK_WORDS + (RAM_AW'(wrPtr_q) >> PACK_SHIFT);
    assign rdAddr = rdInRange ? (RAM_AW'(rdBank_q) * BANK_WORDS + RAM_AW'(rd_addr_i)) : '0;

    generate
        if (PACK != 0) begin : gPacked
            logic [DATA_W-1:0] evenData;
            logic [DATA_W-1:0] oddData;

            mfcc_frame_ram #(.WIDTH(DATA_W), .DEPTH(RAM_DEPTH), .AW(RAM_AW)) uEvenRam (
                .clk_i   (clk_i),
                .we_i    (wrFire && !wrPtr_q[0]),
                .waddr_i (wrAddr),
                .wdata_i (wr_data_i),
                .re_i    (rdFire),
                .raddr_i (rdAddr),
                .rdata_o (evenData)
            );

            mfcc_frame_ram #(.WIDTH(DATA_W), .DEPTH(RAM_DEPTH), .AW(RAM_AW)) uOddRam (
                .clk_i   (clk_i),
                .we_i    (wrFire && wrPtr_q[0]),
                .waddr_i (wrAddr),
                .wdata_i (wr_data_i),
                .re_i    (rdFire),
                .raddr_i (rdAddr),
                .rdata_o (oddData)
            );

            assign ramWord = {oddData, evenData};
        end else begin : gFlat
            logic [DATA_W-1:0] sample;

            mfcc_frame_ram #(.WIDTH(DATA_W), .DEPTH(RAM_DEPTH), .AW(RAM_AW)) uRam (
                .clk_i   (clk_i),
                .we_i    (wrFire),
                .waddr_i (wrAddr),
                .wdata_i (wr_data_i),
                .re_i    (rdFire),
                .raddr_i (rdAddr),
                .rdata_o (sample)
            );

            assign ramWord = {{DATA_W{sample[DATA_W-1]}}, sample};
        end
    endgenerate

    // Next-state for pointers, bank occupancy, frame numbering and overflow.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        wrBank_d   = wrBank_q;
        rdBank_d   = rdBank_q;
        fill_d     = fill_q;
        frameNum_d = frameNum_q;
        ovf_d      = ovf_q || (wr_valid_i && !wr_ready_o);

        if (wrFire) begin
            if (frameDone) begin
                wrPtr_d  = '0;
                wrBank_d = wrBank_q + BANK_W'(1);
            end else begin
                wrPtr_d  = wrPtr_q + PTR_W'(1);
            end
        end

        if (releaseBank) begin
            rdBank_d   = rdBank_q + BANK_W'(1);
            frameNum_d = frameNum_q + FNUM_W'(1);
        end

        // A completing frame and a release in the same cycle cancel out.
        case ({frameDone, releaseBank})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    // State registers; frame_rdy tracks the updated fill so it rises the
    // cycle right after the completing write.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrPtr_q    <= '0;
            wrBank_q   <= '0;
            rdBank_q   <= '0;
            fill_q     <= '0;
            frameNum_q <= '0;
            ovf_q      <= 1'b0;
            frameRdy_q <= 1'b0;
            rdValid_q  <= 1'b0;
            rdErr_q    <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            wrBank_q   <= wrBank_d;
            rdBank_q   <= rdBank_d;
            fill_q     <= fill_d;
            frameNum_q <= frameNum_d;
            ovf_q      <= ovf_d;
            frameRdy_q <= (fill_d != '0);
            rdValid_q  <= rdFire;
            rdErr_q    <= rdFire && !rdInRange;
        end
    end

    assign rd_valid_o  = rdValid_q;
    assign rd_err_o    = rdErr_q;
    assign rd_data_o   = (rdValid_q && !rdErr_q) ? ramWord : '0;
    assign frame_rdy_o = frameRdy_q;
    assign frame_num_o = frameNum_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_mfcc_frame_buf.sv
// Directed testbench for mfcc_frame_buf with FRAME_LEN=8, NUM_BANKS=2.
// An unpacked and a packed instance share every input.
module tb_mfcc_frame_buf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wrValid = 1'b0;
    logic [15:0] wrData = '0;
    logic        rdReq = 1'b0;
    logic [12:0] rdAddr = '0;
    logic        rdDone = 1'b0;

    logic        wrReady, rdValid, rdErr, frameRdy, ovf;
    logic [31:0] rdData;
    logic [7:0]  frameNum;
    logic        pWrReady, pRdValid, pRdErr, pFrameRdy, pOvf;
    logic [31:0] pRdData;
    logic [7:0]  pFrameNum;

    int checks = 0;
    int failures = 0;

    mfcc_frame_buf #(.DATA_W(16), .FRAME_LEN(8), .NUM_BANKS(2), .PACK(0), .ADDR_W(13)) dut (
        .clk_i(clk), .reset_i(reset), .wr_valid_i(wrValid), .wr_ready_o(wrReady),
        .wr_data_i(wrData), .rd_req_i(rdReq), .rd_addr_i(rdAddr), .rd_valid_o(rdValid),
        .rd_data_o(rdData), .rd_err_o(rdErr), .rd_done_i(rdDone), .frame_rdy_o(frameRdy),
        .frame_num_o(frameNum), .ovf_o(ovf)
    );

    mfcc_frame_buf #(.DATA_W(16), .FRAME_LEN(8), .NUM_BANKS(2), .PACK(1), .ADDR_W(13)) dutP (
        .clk_i(clk), .reset_i(reset), .wr_valid_i(wrValid), .wr_ready_o(pWrReady),
        .wr_data_i(wrData), .rd_req_i(rdReq), .rd_addr_i(rdAddr), .rd_valid_o(pRdValid),
        .rd_data_o(pRdData), .rd_err_o(pRdErr), .rd_done_i(rdDone), .frame_rdy_o(pFrameRdy),
        .frame_num_o(pFrameNum), .ovf_o(pOvf)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeFrame(input logic [15:0] base);
        for (int i = 0; i < 8; i++) begin
            wrValid = 1'b1;
            wrData  = base + 16'(i);
            tick();
        end
        wrValid = 1'b0;
    endtask

    task automatic doRead(input logic [12:0] a);
        rdReq  = 1'b1;
        rdAddr = a;
        tick();
        rdReq  = 1'b0;
    endtask

    task automatic releaseFrame();
        rdDone = 1'b1;
        tick();
        rdDone = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (wrReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_ready: got %b expected 0", wrReady); end
        checks++; if (frameRdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_rdy: got %b expected 0", frameRdy); end
        checks++; if (rdValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rdValid); end
        checks++; if (frameNum !== 8'd0) begin failures++; $display("[TB] FAIL reset_frame_num: got %0d expected 0", frameNum); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
        reset = 1'b0;
        #1;
        checks++; if (wrReady !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_wr_ready: got %b expected 1", wrReady); end
    endtask

    task automatic test_stream_read();
        for (int i = 0; i < 8; i++) begin
            wrValid = 1'b1;
            wrData  = 16'(i + 1);
            tick();
            if (i == 6) begin
                checks++; if (frameRdy !== 1'b0) begin failures++; $display("[TB] FAIL early_frame_rdy: got %b expected 0", frameRdy); end
            end
        end
        wrValid = 1'b0;
        checks++; if (frameRdy !== 1'b1) begin failures++; $display("[TB] FAIL frame_rdy_after_8: got %b expected 1", frameRdy); end
        checks++; if (frameNum !== 8'd0) begin failures++; $display("[TB] FAIL first_frame_num: got %0d expected 0", frameNum); end
        for (int i = 0; i < 8; i++) begin
            doRead(13'(i));
            checks++; if (rdValid !== 1'b1) begin failures++; $display("[TB] FAIL read_valid[%0d]: got %b expected 1", i, rdValid); end
            checks++; if (rdData !== 32'(i + 1)) begin failures++; $display("[TB] FAIL read_data[%0d]: got %h expected %h", i, rdData, 32'(i + 1)); end
            if (i == 0) begin
                checks++; if (pRdData !== 32'h0002_0001) begin failures++; $display("[TB] FAIL pack_pair0: got %h expected 00020001", pRdData); end
            end
            if (i == 4) begin
                checks++; if (pRdErr !== 1'b1 || pRdValid !== 1'b1 || pRdData !== 32'h0) begin
                    failures++; $display("[TB] FAIL pack_oob: err=%b valid=%b data=%h expected 1 1 0", pRdErr, pRdValid, pRdData); end
            end
        end
        tick();
        checks++; if (rdValid !== 1'b0) begin failures++; $display("[TB] FAIL rd_valid_drop: got %b expected 0", rdValid); end
        doRead(13'd8);
        checks++; if (rdErr !== 1'b1 || rdValid !== 1'b1 || rdData !== 32'h0) begin
            failures++; $display("[TB] FAIL oob_read: err=%b valid=%b data=%h expected 1 1 0", rdErr, rdValid, rdData); end
        tick();
        checks++; if (rdErr !== 1'b0) begin failures++; $display("[TB] FAIL rd_err_pulse: got %b expected 0", rdErr); end
        releaseFrame();
        checks++; if (frameNum !== 8'd1 || frameRdy !== 1'b0) begin
            failures++; $display("[TB] FAIL release_first: num=%0d rdy=%b expected 1 0", frameNum, frameRdy); end
        doRead(13'd0);
        checks++; if (rdValid !== 1'b0) begin failures++; $display("[TB] FAIL read_not_ready: got %b expected 0", rdValid); end
    endtask

    task automatic test_sign();
        wrValid = 1'b1; wrData = 16'hFFFD; tick();
        wrData = 16'h0005; tick();
        for (int i = 2; i < 8; i++) begin
            wrData = 16'h0000; tick();
        end
        wrValid = 1'b0;
        doRead(13'd0);
        checks++; if (rdData !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL sign_extend: got %h expected FFFFFFFD", rdData); end
        checks++; if (pRdData !== 32'h0005_FFFD) begin failures++; $display("[TB] FAIL pack_signed: got %h expected 0005FFFD", pRdData); end
        releaseFrame();
        checks++; if (frameNum !== 8'd2) begin failures++; $display("[TB] FAIL sign_frame_num: got %0d expected 2", frameNum); end
    endtask

    task automatic test_full_ovf();
        for (int i = 0; i < 16; i++) begin
            wrValid = 1'b1;
            wrData  = 16'(i + 1);
            tick();
            if (i == 7) begin
                checks++; if (wrReady !== 1'b1) begin failures++; $display("[TB] FAIL ready_one_full: got %b expected 1", wrReady); end
            end
        end
        wrValid = 1'b0;
        checks++; if (wrReady !== 1'b0) begin failures++; $display("[TB] FAIL ready_all_full: got %b expected 0", wrReady); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_before: got %b expected 0", ovf); end
        wrValid = 1'b1; wrData = 16'd99; tick(); wrValid = 1'b0;
        checks++; if (ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set: got %b expected 1", ovf); end
        doRead(13'd0);
        checks++; if (rdData !== 32'd1) begin failures++; $display("[TB] FAIL dropped_sample: got %h expected 1", rdData); end
        releaseFrame();
        checks++; if (wrReady !== 1'b1 || frameNum !== 8'd3) begin
            failures++; $display("[TB] FAIL release_full: ready=%b num=%0d expected 1 3", wrReady, frameNum); end
        for (int i = 0; i < 8; i++) begin
            doRead(13'(i));
            checks++; if (rdData !== 32'(i + 9)) begin failures++; $display("[TB] FAIL second_bank[%0d]: got %h expected %h", i, rdData, 32'(i + 9)); end
        end
        doRead(13'd3);
        checks++; if (pRdData !== 32'h0010_000F) begin failures++; $display("[TB] FAIL pack_pair3: got %h expected 0010000F", pRdData); end
        releaseFrame();
        checks++; if (frameRdy !== 1'b0 || ovf !== 1'b1) begin
            failures++; $display("[TB] FAIL drained: rdy=%b ovf=%b expected 0 1", frameRdy, ovf); end
    endtask

    task automatic test_back_to_back();
        writeFrame(16'h0100);
        for (int i = 0; i < 8; i++) begin
            wrValid = 1'b1;
            wrData  = 16'h0200 + 16'(i);
            rdDone  = (i == 7);
            tick();
        end
        wrValid = 1'b0; rdDone = 1'b0;
        checks++; if (frameRdy !== 1'b1 || frameNum !== 8'd5 || wrReady !== 1'b1) begin
            failures++; $display("[TB] FAIL concurrent_done: rdy=%b num=%0d ready=%b expected 1 5 1", frameRdy, frameNum, wrReady); end
        writeFrame(16'h0300);
        checks++; if (wrReady !== 1'b0) begin failures++; $display("[TB] FAIL fill_kept: ready=%b expected 0", wrReady); end
        rdReq = 1'b1; rdAddr = 13'd1; rdDone = 1'b1;
        tick();
        rdReq = 1'b0; rdDone = 1'b0;
        checks++; if (rdData !== 32'h0000_0201 || frameNum !== 8'd6) begin
            failures++; $display("[TB] FAIL read_with_done: data=%h num=%0d expected 00000201 6", rdData, frameNum); end
        doRead(13'd1);
        checks++; if (rdData !== 32'h0000_0301) begin failures++; $display("[TB] FAIL next_bank: got %h expected 00000301", rdData); end
        releaseFrame();
    endtask

    task automatic test_wrap();
        logic [7:0] expNum;
        expNum = 8'd7;
        for (int n = 0; n < 249; n++) begin
            writeFrame(16'(n));
            releaseFrame();
            expNum = expNum + 8'd1;
            if (expNum == 8'd255) begin
                checks++; if (frameNum !== 8'd255) begin failures++; $display("[TB] FAIL frame_num_255: got %0d expected 255", frameNum); end
            end
        end
        checks++; if (frameNum !== 8'd0) begin failures++; $display("[TB] FAIL frame_num_wrap: got %0d expected 0", frameNum); end
    endtask

    task automatic test_reset_mid();
        writeFrame(16'h0500);
        for (int i = 0; i < 5; i++) begin
            wrValid = 1'b1; wrData = 16'h0600 + 16'(i); tick();
        end
        wrValid = 1'b0;
        reset = 1'b1;
        tick();
        checks++; if (wrReady !== 1'b0 || frameRdy !== 1'b0 || frameNum !== 8'd0 || ovf !== 1'b0 || rdValid !== 1'b0) begin
            failures++; $display("[TB] FAIL mid_reset: ready=%b rdy=%b num=%0d ovf=%b valid=%b expected 0 0 0 0 0",
                                 wrReady, frameRdy, frameNum, ovf, rdValid); end
        reset = 1'b0;
        writeFrame(16'h0040);
        checks++; if (frameRdy !== 1'b1) begin failures++; $display("[TB] FAIL fresh_rdy: got %b expected 1", frameRdy); end
        doRead(13'd0);
        checks++; if (rdData !== 32'h0000_0040) begin failures++; $display("[TB] FAIL fresh_first: got %h expected 00000040", rdData); end
        doRead(13'd7);
        checks++; if (rdData !== 32'h0000_0047) begin failures++; $display("[TB] FAIL fresh_last: got %h expected 00000047", rdData); end
        doRead(13'd3);
        checks++; if (pRdData !== 32'h0047_0046) begin failures++; $display("[TB] FAIL fresh_pack: got %h expected 00470046", pRdData); end
    endtask

    initial begin
        test_reset();
        test_stream_read();
        test_sign();
        test_full_ovf();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mfcc_frame_buf.md
Name: mfcc_frame_buf

Overview:
Parametrised multi-bank frame buffer between the sample front end and the MFCC frame processor. It streams fixed-length frames of signed samples into a ring of banks using a valid/ready handshake. It presents the oldest complete frame to the consumer for random-access reads, with 1-cycle latency and optional 2-sample packing. The consumer releases each bank explicitly; frame numbering and overflow reporting are built in.

Parameters:
DATA_W, 16, sample width (signed)
FRAME_LEN, 400, samples per frame; must be even when PACK=1
NUM_BANKS, 2, bank count; power of 2, >=2
PACK, 0, 0: rd_data = sign-extended sample; 1: rd_data = {sample[2k+1], sample[2k]}
ADDR_W, 13, rd_addr width; must satisfy 2^ADDR_W >= FRAME_LEN
OUT_W, 2*DATA_W, rd_data width (derived, not overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous reset, active-high
wr_valid  in  1  sample present on wr_data
wr_ready  out  1  write bank has space
wr_data  in  DATA_W  signed input sample
rd_req  in  1  read request
rd_addr  in  ADDR_W  sample index (PACK=0) or pair index (PACK=1)
rd_valid  out  1  rd_data valid
rd_data  out  OUT_W  read result
rd_err  out  1  1-cycle pulse with rd_valid when the address is out of range
rd_done  in  1  consumer releases the current read bank
frame_rdy  out  1  a complete frame is available for reading
frame_num  out  8  number of the frame presented, wraps 255->0
ovf  out  1  sticky: wr_valid seen while wr_ready=0

Behaviour:
- Reset (clk edge with reset=1): wr_ptr=0, wr_bank=0, rd_bank=0, fill=0, frame_num=0, ovf=0. Outputs rd_valid/rd_err/frame_rdy are 0; wr_ready is 0 while reset is high and 1 on the first cycle after. Reset mid-frame discards partial and full frames; RAM contents are not cleared.
- Storage: one inferred synchronous RAM, NUM_BANKS*FRAME_LEN words of DATA_W; address = bank*FRAME_LEN + index.
- fill = number of full banks, 0..NUM_BANKS.
- wr_ready = (fill < NUM_BANKS).
- Write: on wr_valid && wr_ready, store at (wr_bank, wr_ptr) and increment wr_ptr. When wr_ptr == FRAME_LEN-1: wr_ptr -> 0, wr_bank -> wr_bank+1 mod NUM_BANKS, fill +1.
- ovf is set by wr_valid && !wr_ready; the sample is dropped; ovf clears only on reset.
- frame_rdy = (fill != 0), registered.
- Read: rd_req is honoured only when frame_rdy=1; otherwise it is ignored and rd_valid stays 0.
- Read latency is exactly 1 cycle: rd_valid is high the cycle after rd_req.
- PACK=0: rd_data = sign-extension of sample[rd_addr]; valid range is rd_addr < FRAME_LEN.
- PACK=1: rd_data = {sample[2a+1], sample[2a]}; valid range is a < FRAME_LEN/2. Use a 2-word-wide RAM read or two banked half-RAMs; one rd_req per cycle at full throughput.
- Out-of-range address: rd_data = 0, rd_err=1, rd_valid=1.
- rd_done with fill != 0: rd_bank -> rd_bank+1 mod NUM_BANKS, fill -1, frame_num +1 (mod 256). rd_done with fill == 0 is ignored.
- rd_req and rd_done in the same cycle: the read uses the old rd_bank.
- Frame completion and rd_done in the same cycle: fill stays unchanged and both bank pointers advance.
- All buffer slots full: the write completing the last bank brings fill to NUM_BANKS and wr_ready drops the next cycle. rd_done while full raises wr_ready on the following cycle.
- Bank pointers and frame_num wrap silently.

Decomposition:
- Shared package mfcc_pkg: DATA_W default, FRAME_LEN default (400 = 25 ms @ 16 kHz), frame-number width (8), bank-index width function clog2.
- One sub-module: mfcc_frame_ram, a single-port-write / single-port-read synchronous RAM with parametrised width/depth and 1-cycle read. Control (pointers, fill, handshake) stays in mfcc_frame_buf.

Test Plan (FRAME_LEN=8, NUM_BANKS=2, DATA_W=16 unless stated):
- Reset then stream samples 1..8 -> frame_rdy=1 one cycle after the 8th accept, frame_num=0; rd_addr 0..7 returns 1..8 with rd_valid 1 cycle after each rd_req.
- Write -3 (0xFFFD), read it with PACK=0 -> rd_data=0xFFFFFFFD. PACK=1 with samples 1,2 at pair index 0 -> rd_data=0x00020001.
- Stream 16 samples without rd_done -> wr_ready=0 after the 16th. A 17th wr_valid sets ovf=1 and bank contents are unchanged. rd_done -> wr_ready=1 the next cycle, frame_num=1, reads return samples 9..16.
- rd_addr=8 (PACK=0) or 4 (PACK=1) -> rd_valid=1, rd_err=1, rd_data=0. rd_req with frame_rdy=0 -> no rd_valid.
- 8th write of frame 2 coincides with rd_done of frame 1 -> fill stays 1, frame_rdy stays 1, frame_num increments. Run 300 frames -> frame_num wraps 255->0.
- Assert reset after 5 samples of a frame -> all outputs return to reset values. A fresh frame 1..8 reads back correctly from bank 0.
